// File: rtl/sm83_bus_initiator.sv
// SM83-style bus master: turns single read/write requests into T1..T4 M-cycles
// (plus optional TW wait states) on A/D/MREQ/RD/WR.
module sm83_bus_initiator #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] IDLE_ADDR   = 16'h0000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  input  logic        BUS_DISABLE,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic [15:0] A,
  inout  logic [7:0]  D,
  output logic        MREQ,
  output logic        RD,
  output logic        WR
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] wait_cnt;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       d_oe;
  logic       accept;
  logic       strobe_next;
  logic       sample_read;

  always_comb begin
    REQ_READY = ((state == S_IDLE) || (state == S_T4)) && !BUS_DISABLE && nRESET;
    accept    = REQ_VALID && REQ_READY;
    next_state = state;
    case (state)
      S_IDLE, S_T4: next_state = accept ? S_T1 : S_IDLE;
      S_T1:         next_state = S_T2;
      S_T2:         next_state = S_T3;
      S_T3:         next_state = (WAIT_STATES > 0) ? S_TW : S_T4;
      S_TW:         next_state = (wait_cnt == WAIT_LAST) ? S_T4 : S_TW;
      default:      next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    strobe_next = (next_state == S_T2) || (next_state == S_T3) || (next_state == S_TW);
    sample_read = !wr_q && (next_state == S_T4) && ((state == S_T3) || (state == S_TW));
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      A         <= IDLE_ADDR;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      MREQ      <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      d_oe      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        A       <= REQ_ADDR;
        wr_q    <= REQ_WR;
        wdata_q <= REQ_WDATA;
      end
      if ((state == S_TW) && (next_state == S_TW)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
      MREQ      <= (next_state != S_IDLE);
      RD        <= strobe_next && !wr_q;
      WR        <= strobe_next && wr_q;
      // Write data stays on D through T4 so the falling WR edge sees it stable.
      d_oe      <= wr_q && (strobe_next || (next_state == S_T4));
      RSP_VALID <= sample_read;
      if (sample_read) begin
        RSP_RDATA <= D;
      end
    end
  end

  assign D = d_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_sm83_bus_initiator.sv
// Scoreboarded bench: one initiator with no wait states, one with two, each
// against a simple memory responder on its own bus.
module tb_sm83_bus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        req_valid0, req_valid1, req_wr, bus_disable;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  logic        req_ready0, rsp_valid0, mreq0, rd0, wr0;
  logic        req_ready1, rsp_valid1, mreq1, rd1, wr1;
  logic [7:0]  rsp_rdata0, rsp_rdata1;
  logic [15:0] a0, a1;
  wire  [7:0]  d0, d1;

  sm83_bus_initiator #(.WAIT_STATES(0), .IDLE_ADDR(16'h0000)) dut0 (
    .CLK(clk), .nRESET(n_reset), .REQ_VALID(req_valid0), .REQ_READY(req_ready0),
    .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .BUS_DISABLE(bus_disable), .RSP_VALID(rsp_valid0), .RSP_RDATA(rsp_rdata0),
    .A(a0), .D(d0), .MREQ(mreq0), .RD(rd0), .WR(wr0)
  );

  sm83_bus_initiator #(.WAIT_STATES(2), .IDLE_ADDR(16'hA5A5)) dut1 (
    .CLK(clk), .nRESET(n_reset), .REQ_VALID(req_valid1), .REQ_READY(req_ready1),
    .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .BUS_DISABLE(bus_disable), .RSP_VALID(rsp_valid1), .RSP_RDATA(rsp_rdata1),
    .A(a1), .D(d1), .MREQ(mreq1), .RD(rd1), .WR(wr1)
  );

  // Responders: drive D only while RD is high.
  logic [7:0] rmem0 [65536];
  logic [7:0] rmem1 [65536];
  assign d0 = rd0 ? rmem0[a0] : 8'hzz;
  assign d1 = rd1 ? rmem1[a1] : 8'hzz;

  // Reference model: memory contents as seen by a bus master.
  logic [7:0] model0 [65536];

  typedef struct { logic [7:0] data; int unsigned due; } rsp_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
  rsp_t rq0[$];
  rsp_t rq1[$];
  wr_t  wq0[$];

  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0;
  int unsigned reads0 = 0, reads1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic        wr_prev0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h3E;
      16'h8001: return 8'hA7;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5C;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor / responder write side: pops expectations whenever the DUT presents output.
  initial begin
    rsp_t e;
    wr_t  w;
    for (int i = 0; i < 65536; i++) begin
      rmem0[i] = init_val(16'(i));
      rmem1[i] = init_val(16'(i));
    end
    forever begin
      @(negedge clk);
      if (n_reset) begin
        if (rsp_valid0) begin
          rsp_cnt0++;
          if (rq0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp0_unexpected got=%0h expected=no response", rsp_rdata0);
          end else begin
            e = rq0.pop_front();
            check("rsp0_data", 32'(rsp_rdata0), 32'(e.data));
            check("rsp0_latency", cyc, e.due);
          end
        end
        if (rsp_valid1) begin
          rsp_cnt1++;
          if (rq1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp1_unexpected got=%0h expected=no response", rsp_rdata1);
          end else begin
            e = rq1.pop_front();
            check("rsp1_data", 32'(rsp_rdata1), 32'(e.data));
            check("rsp1_latency", cyc, e.due);
          end
        end
        if (mreq0) check("rd_wr_overlap0", 32'(rd0 & wr0), 32'(0));
        if (mreq1) check("rd_wr_overlap1", 32'(rd1 & wr1), 32'(0));
        if (rd0) check("d_contention0", 32'(d0), 32'(rmem0[a0]));
        if (rd1) check("d_contention1", 32'(d1), 32'(rmem1[a1]));
        if (wr_prev0 && !wr0 && mreq0) begin
          if (wq0.size() == 0) begin
            checks++; failures++;
            $display("FAIL write_unexpected got=%0h@%0h expected=no write", d0, a0);
          end else begin
            w = wq0.pop_front();
            check("write_addr", 32'(a0), 32'(w.addr));
            check("write_data", 32'(d0), 32'(w.data));
          end
          rmem0[a0] = d0;
        end
      end
      wr_prev0 = wr0;
    end
  end

  // Present a request at a falling edge, wait for acceptance, return at the T1 falling edge.
  task automatic issue(input int lane, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    int unsigned n;
    logic        rdy;
    rsp_t        e;
    n = 0;
    req_wr = wr; req_addr = addr; req_wdata = wd;
    if (lane == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    #1;
    rdy = (lane == 0) ? req_ready0 : req_ready1;
    while (!rdy && n < 64) begin
      @(negedge clk); #1;
      rdy = (lane == 0) ? req_ready0 : req_ready1;
      n++;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout lane=%0d got=not ready expected=accept within 64 cycles", lane);
    end else if (!wr) begin
      // The accepting cycle is cycle 0; the response lands in cycle 4+W.
      e.data = (lane == 0) ? model0[addr] : init_val(addr);
      e.due  = cyc + 4 + ((lane == 0) ? 0 : 2);
      if (lane == 0) begin rq0.push_back(e); reads0++; end
      else begin rq1.push_back(e); reads1++; end
    end else begin
      model0[addr] = wd;
      wq0.push_back('{addr: addr, data: wd});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic trace(input int lane, input string name, input int n,
                       input logic [15:0] mreq_e, input logic [15:0] rd_e,
                       input logic [15:0] wr_e, input logic [15:0] rdy_e);
    logic [15:0] m, r, w, y;
    m = '0; r = '0; w = '0; y = '0;
    for (int i = 0; i < n; i++) begin
      m = {m[14:0], (lane == 0) ? mreq0 : mreq1};
      r = {r[14:0], (lane == 0) ? rd0 : rd1};
      w = {w[14:0], (lane == 0) ? wr0 : wr1};
      y = {y[14:0], (lane == 0) ? req_ready0 : req_ready1};
      if (i < n - 1) @(negedge clk);
    end
    check({name, "_mreq"}, 32'(m), 32'(mreq_e));
    check({name, "_rd"}, 32'(r), 32'(rd_e));
    check({name, "_wr"}, 32'(w), 32'(wr_e));
    check({name, "_ready"}, 32'(y), 32'(rdy_e));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int unsigned c0, c1;
    int unsigned n;
    logic [15:0] pool [8];
    pool = '{16'h0100, 16'hC000, 16'h8001, 16'h1234, 16'h0000, 16'h4000, 16'h7FFF, 16'hFFFF};
    for (int i = 0; i < 65536; i++) model0[i] = init_val(16'(i));

    n_reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_wr = 1'b0;
    bus_disable = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_a0", 32'(a0), 32'(16'h0000));
    check("rst_a1", 32'(a1), 32'(16'hA5A5));
    check("rst_strobes0", 32'({mreq0, rd0, wr0, rsp_valid0}), 32'(0));
    check("rst_rdata0", 32'(rsp_rdata0), 32'(0));
    check("rst_ready0", 32'(req_ready0), 32'(0));
    n_reset = 1'b1;

    // Single read, no wait states.
    issue(0, 1'b0, 16'h0100, 8'h00);
    req_valid0 = 1'b0;
    trace(0, "t1", 5, 16'b11110, 16'b01100, 16'b00000, 16'b00011);

    // Back-to-back write then read of the same address.
    issue(0, 1'b1, 16'hC000, 8'h5A);
    c1 = cyc;
    issue(0, 1'b0, 16'hC000, 8'h00);
    req_valid0 = 1'b0;
    check("t2_no_bubble", cyc - c1, 32'd4);
    trace(0, "t2", 5, 16'b11110, 16'b01100, 16'b00000, 16'b00011);

    // Two wait states.
    issue(1, 1'b0, 16'h8001, 8'h00);
    req_valid1 = 1'b0;
    trace(1, "t3", 7, 16'b1111110, 16'b0111100, 16'b0000000, 16'b0000011);

    // BUS_DISABLE holds off a pending request.
    bus_disable = 1'b1; req_wr = 1'b0; req_addr = 16'h1234; req_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_held", 32'({req_ready0, mreq0, rd0, wr0}), 32'(0));
      check("t4_addr", 32'(a0), 32'(16'hC000));
      @(negedge clk);
    end
    bus_disable = 1'b0;
    c0 = cyc;
    issue(0, 1'b0, 16'h1234, 8'h00);
    req_valid0 = 1'b0;
    check("t4_accept_next_edge", cyc - c0, 32'd1);
    check("t4_t1", 32'({mreq0, a0}), 32'({1'b1, 16'h1234}));
    repeat (4) @(negedge clk);

    // Reset during T2 of a write.
    issue(0, 1'b1, 16'hFF80, 8'h66);
    req_valid0 = 1'b0;
    @(negedge clk);
    check("t5_in_t2", 32'(wr0), 32'(1));
    n_reset = 1'b0;
    #1;
    check("t5_strobes", 32'({mreq0, rd0, wr0, rsp_valid0}), 32'(0));
    check("t5_addr", 32'(a0), 32'(16'h0000));
    wq0.delete();
    @(negedge clk);
    n_reset = 1'b1;
    c0 = cyc;
    issue(0, 1'b0, 16'h0000, 8'h00);
    req_valid0 = 1'b0;
    check("t5_first_accept", cyc - c0, 32'd1);
    repeat (5) @(negedge clk);

    // Randomised traffic against the model; 0xFF80 is never read again.
    for (int i = 0; i < 64; i++) begin
      issue(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req_valid0 = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid0 = 1'b0;

    n = 0;
    while ((rq0.size() + rq1.size() + wq0.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", rq0.size() + rq1.size() + wq0.size(), 32'd0);
    check("rsp_count0", rsp_cnt0, reads0);
    check("rsp_count1", rsp_cnt1, reads1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm83_bus_initiator.md
Name: sm83_bus_initiator

Overview:
Bus-master counterpart to the SM83 memory/MMIO responder models. It turns single-transfer read/write requests from a bench sequencer or DMA-style engine into SM83-style M-cycles on A/D/MREQ/RD/WR. Each M-cycle is four T-states of CLK, plus optional wait states. It lets memory models and peripherals be exercised without the full core.

Parameters:
WAIT_STATES, 0, extra TW cycles inserted between T3 and T4 on every M-cycle (0..15).
IDLE_ADDR, 16'h0000, value driven on A after reset, before the first request.

Ports:
CLK  input  1  T-state clock; all state changes on rising edge.
nRESET  input  1  asynchronous, active-low reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  request accepted when REQ_VALID & REQ_READY at a rising CLK.
REQ_WR  input  1  1 = write, 0 = read.
REQ_ADDR  input  16  transfer address.
REQ_WDATA  input  8  write data.
BUS_DISABLE  input  1  when high, no new M-cycle starts; an in-flight cycle completes.
RSP_VALID  output  1  one-cycle pulse carrying read data.
RSP_RDATA  output  8  read data, valid when RSP_VALID is high.
A  output  16  address bus.
D  inout  8  data bus; driven only during write T2..T4, high-Z otherwise.
MREQ  output  1  active-high memory request.
RD  output  1  active-high read strobe.
WR  output  1  active-high write strobe.

Behaviour:
- States: IDLE, T1, T2, T3, TW, T4. All outputs are registered except REQ_READY.
- REQ_READY = (state==IDLE or state==T4) & !BUS_DISABLE & nRESET.
- Acceptance: ADDR, WR and WDATA are captured into internal registers. The next state is T1, so back-to-back M-cycles have no idle bubble.
- No acceptance in IDLE or T4: next state is IDLE.
- T1: A = captured address; MREQ=1; RD=0; WR=0; D high-Z.
- T2:
  - read: RD=1.
  - write: D driven with WDATA; WR=1.
- T3: same strobes as T2.
- TW: entered from T3 when WAIT_STATES>0, repeated WAIT_STATES times via a 4-bit counter. Strobes are the same as T3.
- Read sample: D is sampled on the rising edge that leaves the last of T3/TW (the edge entering T4).
- T4 (read): RD=0; MREQ=1; RSP_VALID=1 for exactly this cycle; RSP_RDATA = sampled value.
- T4 (write): WR=0, so the falling WR edge commits the write at the responder. A and D are still held for the whole of T4; D is released on leaving T4. MREQ=1.
- Leaving T4 to IDLE: MREQ=0 and A holds its last value. The bus never floats A.
- Leaving T4 to T1: MREQ stays 1. A changes to the new address at the T1 edge, one full cycle after the WR fall.
- RD and WR are never high simultaneously. D is never driven while RD=1.
- RSP_RDATA holds its value until the next read response. It is never updated by writes.
- BUS_DISABLE rising mid-cycle has no effect until T4. It only gates REQ_READY.
- Reset (nRESET low), asynchronous: state=IDLE, A=IDLE_ADDR, MREQ=RD=WR=0, D high-Z, RSP_VALID=0, RSP_RDATA=8'h00, wait counter=0.
- Reset mid-cycle: the in-flight transfer is dropped and no response is produced. A write aborted before T4 may or may not have committed at the responder. The bench must not rely on either outcome.
- Leaving reset: first acceptance possible at the first rising edge with nRESET high.
- Latency with W = WAIT_STATES:
  - acceptance edge to RSP_VALID = 4+W cycles;
  - throughput = one transfer per 4+W cycles.
- Addresses are full 16-bit; no wrap or increment logic. Each request is independent.

Test Plan:
1. Reset, then a single read of A=16'h0100 with responder mem[0x0100]=8'h3E, WAIT_STATES=0:
   - MREQ high for 4 cycles, RD high in T2–T3;
   - RSP_VALID pulses 4 cycles after acceptance with RSP_RDATA=8'h3E;
   - D never driven by the initiator.
2. Write 8'h5A to 16'hC000, then read 16'hC000 back-to-back (REQ_VALID held):
   - no idle cycle between M-cycles; WR falls at T4 with A=C000 and D=5A stable;
   - read returns 8'h5A; RD and WR never overlap.
3. WAIT_STATES=2, read 16'h8001 holding 8'hA7:
   - RD high for 4 cycles;
   - RSP_VALID 6 cycles after acceptance with 8'hA7;
   - REQ_READY low from acceptance until T4.
4. BUS_DISABLE=1 with REQ_VALID=1 in IDLE for 10 cycles:
   - REQ_READY=0, MREQ/RD/WR stay 0, A unchanged.
   - Drop BUS_DISABLE: acceptance on the next edge, T1 follows.
5. Assert nRESET low during T2 of a write to 16'hFF80:
   - WR, MREQ and RD go 0 immediately; D goes high-Z; A=IDLE_ADDR; no RSP_VALID.
   - After release, a read of 16'h0000 completes normally.
6. 64 random reads/writes against the memory model, scoreboarded:
   - every read matches the last write to that address;
   - RSP_VALID count equals the read count;
   - D is never driven while RD=1 (checked by assertion).
